// File: rtl/router_pkg.sv
// Shared router SPI definitions: FSM encodings, default frame width
// and a counter-width helper used by the transmit and receive blocks.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } spi_state_t;

  localparam int SIZE_DEFAULT = 8;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// HALF-cycle tick generator; tick is high in the last cycle of each
// half-period and the count restarts on tick or clear.
module spi_clk_div
  import router_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DW = cnt_w(HALF);

  logic [DW-1:0] cnt;

  assign tick = (cnt == DW'(HALF - 1));

  always_ff @(posedge clock) begin
    if (reset || clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + DW'(1);
  end

endmodule

// File: rtl/spi_port_tx.sv
// SPI mode-0 master for the router egress path: serialises the active
// port's byte MSB first on a per-port chip select.
module spi_port_tx
  import router_pkg::*;
#(
  parameter int size = SIZE_DEFAULT,
  parameter int HALF = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            port1,
  input  logic            port2,
  input  logic [size-1:0] port1Data,
  input  logic [size-1:0] port2Data,
  output logic            sclk,
  output logic            mosi,
  output logic            cs1_n,
  output logic            cs2_n,
  output logic            busy,
  output logic            done
);

  localparam int BW = cnt_w(size);

  spi_state_t      state;
  logic [size-1:0] sreg;
  logic [BW-1:0]   bits;
  logic            tick;
  logic            clear;

  // Divider is held at zero while idle so SHIFT starts on a fresh half.
  assign clear = (state == IDLE);

  spi_clk_div #(
    .HALF(HALF)
  ) u_div (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      bits  <= '0;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
      cs1_n <= 1'b1;
      cs2_n <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (port1 || port2) begin
            sreg  <= port1 ? port1Data : port2Data;
            mosi  <= port1 ? port1Data[size-1]
                           : port2Data[size-1];
            cs1_n <= ~port1;
            cs2_n <= port1;
            busy  <= 1'b1;
            bits  <= BW'(size - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bits == '0) begin
              sclk  <= 1'b0;
              mosi  <= 1'b0;
              cs1_n <= 1'b1;
              cs2_n <= 1'b1;
              done  <= 1'b1;
              state <= GAP;
            end else begin
              // Rotate so the next bit always sits at size-2.
              sclk <= 1'b0;
              sreg <= {sreg[size-2:0], sreg[size-1]};
              mosi <= sreg[size-2];
              bits <= bits - BW'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_port_tx.md
# spi_port_tx

Serial transmitter for the router's egress path. It takes the active port's byte, selected by the same `port1`/`port2` request levels that drive the router's parallel output stage, and shifts it out as an SPI mode-0 master frame on a dedicated chip select per port. It sits between the router core and the off-chip SPI slaves and converts the router's parallel port data into the serial link.

## Interface
Parameters:
- `size`, 8, frame width in bits; also the width of `port1Data`/`port2Data`.
- `HALF`, 2, `clock` cycles per SCLK half-period; legal range ≥ 1.

Ports:
- `clock`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `port1`  input  1  level request to transmit `port1Data` on port 1.
- `port2`  input  1  level request to transmit `port2Data` on port 2.
- `port1Data`  input  size  byte for port 1.
- `port2Data`  input  size  byte for port 2.
- `sclk`  output  1  SPI clock; idles low.
- `mosi`  output  1  serial data, MSB first.
- `cs1_n`  output  1  active-low chip select, port 1.
- `cs2_n`  output  1  active-low chip select, port 2.
- `busy`  output  1  high from frame start until the end of GAP.
- `done`  output  1  one-cycle pulse at frame completion.

## Operation
- All outputs are registered.
- Reset values: `sclk`=0, `mosi`=0, `cs1_n`=1, `cs2_n`=1, `busy`=0, `done`=0. State returns to IDLE and all counters clear.
- Reset mid-frame: outputs take their reset values on the next edge. No `done` pulse. The partially shifted frame is discarded.
- FSM states: IDLE, SHIFT, GAP.
- **IDLE:** requests are sampled on every edge.
  - If `port1`=1, capture `port1Data`. Else if `port2`=1, capture `port2Data`. Port 1 has fixed priority.
  - Capture drives the selected `cs_n` low, puts the MSB on `mosi`, sets `busy`=1, loads the bit counter with size-1 and the divider with 0, then moves to SHIFT.
- **SHIFT:** each bit occupies 2·HALF cycles, HALF with `sclk` low followed by HALF with `sclk` high.
  - The slave samples on the rising `sclk` edge.
  - On each high→low transition with bits remaining, shift the next bit onto `mosi` and decrement the bit counter.
  - After the high half of the LSB: `sclk`→0, the selected `cs_n`→1, `mosi`→0, `done`=1 for that cycle, then move to GAP.
- **GAP:** HALF cycles with both chip selects high and `busy`=1, then IDLE.
- Requests are ignored outside IDLE. They are not queued: a request must still be high when IDLE is re-entered to be served.
- Captured data is frozen for the whole frame. Changes on `portXData` during a frame have no effect.
- At most one `cs_n` is low at any time.

## Timing
- Request high at edge k (in IDLE): `cs_n` is low and `mosi` carries the MSB from edge k.
- First `sclk` rise occurs at edge k+HALF.
- `cs_n` stays low for exactly 2·HALF·size cycles (32 at the defaults).
- `done` coincides with the first cycle in which `cs_n` is high again.
- Minimum inter-frame `cs_n` high time is HALF+1 cycles: HALF GAP cycles plus one IDLE sample.
- Back-to-back frame period is 2·HALF·size + HALF + 1 cycles.
- Divider counter width is clog2(HALF)+1. Bit counter width is clog2(size)+1. Neither counter wraps; both are reloaded at each state entry.

## Structure
- Shared package `router_pkg`: FSM state encodings (IDLE, SHIFT, GAP) and the default `size`. These are shared with the future SPI receive block.
- Sub-module `spi_clk_div`: HALF-cycle tick generator with `clear` and `tick` signals, reused by the receiver. The FSM, shift register, and chip-select logic stay in `spi_port_tx`.

## Test plan
All scenarios use `size`=8 and `HALF`=2 unless stated otherwise.
1. `port1`=1 for one cycle with `port1Data`=8'hA5 → `cs1_n` low 32 cycles, `cs2_n` stays 1. `mosi` at the 8 `sclk` rises reads 1,0,1,0,0,1,0,1. Exactly one `done` pulse.
2. `port1`=`port2`=1 with data 8'h3C/8'hC3 → only `cs1_n` asserts and 8'h3C is shifted.
3. `port2` with 8'h81, then `port1` raised mid-frame and held → the 8'h81 frame completes untouched on `cs2_n`. After a cs-high gap of ≥3 cycles, an 8'h.. frame starts on `cs1_n` using `port1Data` as sampled in IDLE.
4. `reset` asserted at cycle 10 of a frame → on the next edge, all outputs at reset values and no `done`. A following request sends a complete frame starting from the MSB.
5. `HALF`=1, `port1` held high with 8'hFF → `sclk` period 2 cycles, `cs1_n` low 16 cycles, repeating frames every 18 cycles, `mosi`=1 during every frame.
6. Change `port1Data` from 8'h0F to 8'hF0 during a frame → the transmitted bits remain 8'h0F.
